// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 edge-preserving filter: frame sequencer
// state encoding and datapath-wide constants.
package filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DEF_LAT = 10;
   localparam int PIX_W   = 8;

endpackage

// File: rtl/filter_frame_ctrl_if.sv
// Handshake bundle between the video source / filter core (master side)
// and the frame sequencer (slave side).
interface filter_frame_ctrl_if #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic          act;
   logic          wr;
   logic          out_valid;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      output start, in_valid, wr,
      input  in_ready, act, out_valid, out_x, out_y, busy, done, err
   );

   modport slave (
      input  start, in_valid, wr,
      output in_ready, act, out_valid, out_x, out_y, busy, done, err
   );
endinterface

// File: rtl/frame_xy_counter.sv
// Raster x/y counter: x runs X_START..X_END, then wraps and steps y through
// Y_START..Y_END. wrap flags the final position of the raster.
module frame_xy_counter #(
   parameter int XW      = 4,
   parameter int YW      = 4,
   parameter int X_START = 0,
   parameter int X_END   = 3,
   parameter int Y_START = 0,
   parameter int Y_END   = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          wrap
);
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          x_last;

   assign x_last = (x_q == XW'(X_END));
   assign wrap   = x_last && (y_q == YW'(Y_END));
   assign x      = x_q;
   assign y      = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr) begin
         x_d = XW'(X_START);
         y_d = YW'(Y_START);
      end else if (en) begin
         if (x_last) begin
            x_d = XW'(X_START);
            y_d = (y_q == YW'(Y_END)) ? YW'(Y_START) : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end
endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for the 3x3 filter: gates act on interior windows, tracks
// in-flight windows and numbers filter outputs. FILTER_FRAME_CTRL_TIMEOUT_EN adds a drain watchdog.
module filter_frame_ctrl
   import filter_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int LAT   = DEF_LAT
) (
   input  logic               clk,
   input  logic               rst_n,
   filter_frame_ctrl_if.slave bus
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int OW = $clog2(LAT + 2);

   state_e        state_q, state_d;
   logic [XW-1:0] in_x, oc_x, out_x_q, out_x_d;
   logic [YW-1:0] in_y, oc_y, out_y_q, out_y_d;
   logic [OW-1:0] outst_q, outst_d;
   logic          in_wrap, out_wrap_unused;
   logic          act_q, act_d, out_valid_q, out_valid_d, err_q, err_d;
   logic          start_ok, accept, wr_ok, timeout;

   assign start_ok = bus.start && (state_q == ST_IDLE);
   assign accept   = bus.in_valid && (state_q == ST_RUN);
   // A wr with nothing in flight is spurious and must not advance the output raster.
   assign wr_ok    = bus.wr && (outst_q != '0);

   frame_xy_counter #(
      .XW(XW), .YW(YW), .X_START(0), .X_END(IMG_W - 1), .Y_START(0), .Y_END(IMG_H - 1)
   ) u_in_cnt (
      .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(accept),
      .x(in_x), .y(in_y), .wrap(in_wrap)
   );

   frame_xy_counter #(
      .XW(XW), .YW(YW), .X_START(1), .X_END(IMG_W - 2), .Y_START(1), .Y_END(IMG_H - 2)
   ) u_out_cnt (
      .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(wr_ok),
      .x(oc_x), .y(oc_y), .wrap(out_wrap_unused)
   );

`ifdef FILTER_FRAME_CTRL_TIMEOUT_EN
   localparam int WW = $clog2(LAT + 5);
   logic [WW-1:0] wd_q, wd_d;

   assign timeout = (state_q == ST_DRAIN) && !bus.wr && (outst_q != '0) &&
                    (wd_q == WW'(LAT + 3));

   always_comb begin
      wd_d = '0;
      if ((state_q == ST_DRAIN) && !bus.wr)
         wd_d = (outst_q != '0) ? wd_q + 1'b1 : wd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_q <= '0;
      else        wd_q <= wd_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      act_d       = accept && (in_x >= XW'(2)) && (in_y >= YW'(2));
      out_valid_d = wr_ok;
      out_x_d     = wr_ok ? oc_x : out_x_q;
      out_y_d     = wr_ok ? oc_y : out_y_q;
      outst_d     = outst_q;
      if (start_ok || timeout)
         outst_d = '0;
      else if (act_q && !wr_ok)
         outst_d = outst_q + 1'b1;
      else if (!act_q && wr_ok)
         outst_d = outst_q - 1'b1;
      err_d = err_q;
      if (start_ok)
         err_d = 1'b0;
      if ((bus.wr && !wr_ok) || timeout)
         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         outst_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         act_q       <= act_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         outst_q     <= outst_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // DRAIN looks at the next outstanding count so done follows the last wr directly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_RUN;
         ST_RUN:   if (accept && in_wrap) state_d = ST_DRAIN;
         ST_DRAIN: if (outst_d == '0) state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = (state_q == ST_RUN);
      bus.busy     = (state_q != ST_IDLE);
      bus.done     = (state_q == ST_DONE);
   end

   assign bus.act       = act_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_x     = out_x_q;
   assign bus.out_y     = out_y_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Bench for filter_frame_ctrl on a 5x4 frame: a cycle-level reference model
// built from frame-level arithmetic, plus a delay-line filter model.
module tb_filter_frame_ctrl;
   localparam int IMG_W = 5;
   localparam int IMG_H = 4;
   localparam int LAT   = 10;
   localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);
   localparam int NPIX  = IMG_W * IMG_H;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   filter_frame_ctrl_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

   filter_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // model state: 0 idle, 1 run, 2 drain, 3 done
   int m_state = 0, acc_n = 0, out_n = 0, m_out = 0, wd = 0;
   bit m_err = 0, exp_act = 0, exp_ov = 0;
   int exp_x = 0, exp_y = 0;
   int cyc = 0, act_cnt = 0, last_act_cyc = 0, done_cnt = 0, done_cyc = 0;
   int ov_cnt = 0, dut_acc = 0, emit_n = 0;
   bit hist [64];
   bit force_wr = 0, drop_last = 0;
   bit pend, wr_ok, nxt_act;
   int nxt_out, nxt_state;

   initial begin
      bus.wr = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            m_state = 0; acc_n = 0; out_n = 0; m_out = 0; wd = 0;
            m_err = 0; exp_act = 0; exp_ov = 0; exp_x = 0; exp_y = 0; emit_n = 0;
            for (int i = 0; i < 64; i++) hist[i] = 1'b0;
         end
         check_eq("in_ready", bus.in_ready, m_state == 1);
         check_eq("busy", bus.busy, m_state != 0);
         check_eq("done", bus.done, m_state == 3);
         check_eq("err", bus.err, m_err);
         check_eq("act", bus.act, exp_act);
         check_eq("out_valid", bus.out_valid, exp_ov);
         check_eq("out_x", bus.out_x, exp_x);
         check_eq("out_y", bus.out_y, exp_y);
         if (bus.act) begin act_cnt++; last_act_cyc = cyc; end
         if (bus.done) begin done_cnt++; done_cyc = cyc; end
         if (bus.out_valid) ov_cnt++;
         if (bus.in_valid && bus.in_ready) dut_acc++;

         // filter: every act comes back as wr exactly LAT cycles later
         hist[cyc % 64] = bus.act;
         pend = rst_n && (cyc >= LAT) && hist[(cyc - LAT) % 64];
         if (pend && drop_last && emit_n == NOUT - 1) pend = 1'b0;
         else if (pend) emit_n++;
         bus.wr = pend | force_wr;

         if (rst_n) begin
            wr_ok     = bus.wr && (m_out > 0);
            nxt_out   = m_out + (exp_act ? 1 : 0) - (wr_ok ? 1 : 0);
            nxt_state = m_state;
            nxt_act   = 1'b0;
            if (m_state != 2) wd = 0;
            case (m_state)
               0: if (bus.start) begin
                     acc_n = 0; out_n = 0; m_err = 0; emit_n = 0; nxt_state = 1;
                  end
               1: if (bus.in_valid) begin
                     nxt_act = (acc_n % IMG_W >= 2) && (acc_n / IMG_W >= 2);
                     acc_n++;
                     if (acc_n == NPIX) nxt_state = 2;
                  end
               2: begin
`ifdef FILTER_FRAME_CTRL_TIMEOUT_EN
                     if (bus.wr) wd = 0;
                     else if (m_out > 0) begin
                        wd++;
                        if (wd == LAT + 4) begin m_err = 1; nxt_out = 0; end
                     end
`endif
                     if (nxt_out == 0) nxt_state = 3;
                  end
               default: nxt_state = 0;
            endcase
            if (bus.wr && !wr_ok) m_err = 1;
            if (wr_ok) begin
               exp_x = 1 + out_n % (IMG_W - 2);
               exp_y = 1 + out_n / (IMG_W - 2);
               out_n++;
            end
            exp_ov  = wr_ok;
            exp_act = nxt_act;
            m_out   = nxt_out;
            m_state = nxt_state;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int mode, input bit mid_start, input bit want_done);
      int a0, c0, o0, d0;
      bit seen;
      a0 = dut_acc; c0 = act_cnt; o0 = ov_cnt; d0 = done_cnt; seen = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_eq("err_after_start", bus.err, 0);
      for (int i = 0; i < 150 && !seen; i++) begin
         case (mode)
            0:       bus.in_valid = 1'b1;
            1:       bus.in_valid = (i % 2 == 0);
            default: bus.in_valid = 1'($urandom_range(0, 1));
         endcase
         bus.start = mid_start && (i == 6);
         tick();
         seen = (done_cnt != d0);
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      check_eq("frame_accepts", dut_acc - a0, NPIX);
      check_eq("frame_acts", act_cnt - c0, NOUT);
      if (want_done) begin
         check_eq("frame_done_seen", seen, 1);
         check_eq("frame_done_count", done_cnt - d0, 1);
         if (!drop_last) begin
            check_eq("frame_outputs", ov_cnt - o0, NOUT);
            check_eq("done_after_last_act", done_cyc - last_act_cyc, LAT + 1);
            check_eq("frame_err", bus.err, 0);
         end else begin
            check_eq("timeout_outputs", ov_cnt - o0, NOUT - 1);
            check_eq("timeout_err", bus.err, 1);
         end
      end else begin
         check_eq("hang_no_done", done_cnt - d0, 0);
         check_eq("hang_busy", bus.busy, 1);
      end
   endtask

   initial begin
      int a0, d0, o0;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      repeat (3) tick();
      check_eq("rst_in_ready", bus.in_ready, 0);
      check_eq("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      run_frame(0, 1'b0, 1'b1);
      run_frame(1, 1'b0, 1'b1);
      run_frame(2, 1'b1, 1'b1);

      // spurious wr in IDLE
      o0 = ov_cnt;
      force_wr = 1'b1; tick(); force_wr = 1'b0;
      repeat (2) tick();
      check_eq("idle_wr_err", bus.err, 1);
      check_eq("idle_wr_no_out", ov_cnt - o0, 0);
      run_frame(2, 1'b0, 1'b1);
      o0 = ov_cnt;
      force_wr = 1'b1; tick(); force_wr = 1'b0;
      repeat (2) tick();
      check_eq("extra_wr_err", bus.err, 1);
      check_eq("extra_wr_no_out", ov_cnt - o0, 0);

      // reset mid-frame
      a0 = dut_acc; d0 = done_cnt;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50 && (dut_acc - a0) < 12; i++) tick();
      check_eq("reached_12_accepts", dut_acc - a0, 12);
      rst_n = 1'b0;
      #1;
      check_eq("arst_in_ready", bus.in_ready, 0);
      check_eq("arst_act", bus.act, 0);
      check_eq("arst_out_valid", bus.out_valid, 0);
      check_eq("arst_out_x", bus.out_x, 0);
      check_eq("arst_out_y", bus.out_y, 0);
      check_eq("arst_busy", bus.busy, 0);
      check_eq("arst_err", bus.err, 0);
      bus.in_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check_eq("arst_no_done", done_cnt - d0, 0);
      run_frame(0, 1'b0, 1'b1);

      // last wr lost by the filter
      drop_last = 1'b1;
`ifdef FILTER_FRAME_CTRL_TIMEOUT_EN
      run_frame(0, 1'b0, 1'b1);
      drop_last = 1'b0;
`else
      run_frame(0, 1'b0, 1'b0);
      drop_last = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
`endif
      run_frame(2, 1'b0, 1'b1);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
